// File: rtl/reg_slice_cfg.sv
// Configurable valid/ready register slice: bypass, forward-registered,
// backward-registered (skid) or fully registered two-entry buffer.
module reg_slice_cfg #(
    parameter int unsigned PLD_WIDTH = 32,
    parameter int unsigned MODE      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_vld,
    output logic                 s_rdy,
    input  logic [PLD_WIDTH-1:0] s_pld,
    output logic                 m_vld,
    input  logic                 m_rdy,
    output logic [PLD_WIDTH-1:0] m_pld,
    output logic [1:0]           occ
);

    if (PLD_WIDTH < 1 || MODE > 3) begin : g_bad_cfg
        $error("reg_slice_cfg: PLD_WIDTH must be >= 1 and MODE must be 0..3");
    end

    if (MODE == 0) begin : g_bypass
        // Pure wires; clock and reset have no role here.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign m_vld = s_vld;
        assign m_pld = s_pld;
        assign s_rdy = m_rdy;
        assign occ   = 2'd0;
    end else if (MODE == 1) begin : g_fwd
        logic                 m_vld_q, m_vld_d;
        logic [PLD_WIDTH-1:0] m_pld_q, m_pld_d;

        always_comb begin
            m_vld_d = m_vld_q;
            m_pld_d = m_pld_q;
            if (s_vld && s_rdy) begin
                m_vld_d = 1'b1;
                m_pld_d = s_pld;
            end else if (m_rdy) begin
                m_vld_d = 1'b0;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) m_vld_q <= 1'b0;
            else     m_vld_q <= m_vld_d;
        end

        always_ff @(posedge clk) begin
            m_pld_q <= m_pld_d;
        end

        assign s_rdy = ~m_vld_q | m_rdy;
        assign m_vld = m_vld_q;
        assign m_pld = m_pld_q;
        assign occ   = {1'b0, m_vld_q};
    end else if (MODE == 2) begin : g_bwd
        logic                 skid_vld_q, skid_vld_d;
        logic [PLD_WIDTH-1:0] skid_pld_q, skid_pld_d;
        logic                 s_rdy_q, s_rdy_d;

        // Skid catches the beat accepted in a cycle the sink stalled.
        always_comb begin
            skid_vld_d = skid_vld_q;
            skid_pld_d = skid_pld_q;
            if (skid_vld_q && m_rdy) begin
                skid_vld_d = 1'b0;
            end else if (s_vld && s_rdy_q && !m_rdy) begin
                skid_vld_d = 1'b1;
                skid_pld_d = s_pld;
            end
            s_rdy_d = ~skid_vld_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                skid_vld_q <= 1'b0;
                s_rdy_q    <= 1'b1;
            end else begin
                skid_vld_q <= skid_vld_d;
                s_rdy_q    <= s_rdy_d;
            end
        end

        always_ff @(posedge clk) begin
            skid_pld_q <= skid_pld_d;
        end

        assign s_rdy = s_rdy_q;
        assign m_vld = s_vld | skid_vld_q;
        assign m_pld = skid_vld_q ? skid_pld_q : s_pld;
        assign occ   = {1'b0, skid_vld_q};
    end else if (MODE == 3) begin : g_full
        logic                 out_vld_q, out_vld_d;
        logic [PLD_WIDTH-1:0] out_pld_q, out_pld_d;
        logic                 skid_vld_q, skid_vld_d;
        logic [PLD_WIDTH-1:0] skid_pld_q, skid_pld_d;
        logic                 s_rdy_q, s_rdy_d;
        logic                 up, dn;

        assign up = s_vld & s_rdy_q;
        assign dn = out_vld_q & m_rdy;

        // s_rdy_q mirrors ~skid_vld_q, so an upstream beat never meets a full skid.
        always_comb begin
            out_vld_d  = out_vld_q;
            out_pld_d  = out_pld_q;
            skid_vld_d = skid_vld_q;
            skid_pld_d = skid_pld_q;
            if (dn) begin
                if (skid_vld_q) begin
                    out_pld_d  = skid_pld_q;
                    skid_vld_d = 1'b0;
                end else if (up) begin
                    out_pld_d = s_pld;
                end else begin
                    out_vld_d = 1'b0;
                end
            end else if (up) begin
                if (!out_vld_q) begin
                    out_vld_d = 1'b1;
                    out_pld_d = s_pld;
                end else begin
                    skid_vld_d = 1'b1;
                    skid_pld_d = s_pld;
                end
            end
            s_rdy_d = ~skid_vld_d;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                out_vld_q  <= 1'b0;
                skid_vld_q <= 1'b0;
                s_rdy_q    <= 1'b1;
            end else begin
                out_vld_q  <= out_vld_d;
                skid_vld_q <= skid_vld_d;
                s_rdy_q    <= s_rdy_d;
            end
        end

        always_ff @(posedge clk) begin
            out_pld_q  <= out_pld_d;
            skid_pld_q <= skid_pld_d;
        end

        assign s_rdy = s_rdy_q;
        assign m_vld = out_vld_q;
        assign m_pld = out_pld_q;
        assign occ   = {1'b0, out_vld_q} + {1'b0, skid_vld_q};
    end

endmodule

// File: tb/tb_reg_slice_cfg.sv
// Bench for reg_slice_cfg: one instance per MODE, each driven with independent
// random traffic and compared against an ordered-queue model of held payloads.
module tb_reg_slice_cfg;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic         s_vld [4];
    logic         s_rdy [4];
    logic [W-1:0] s_pld [4];
    logic         m_vld [4];
    logic         m_rdy [4];
    logic [W-1:0] m_pld [4];
    logic [1:0]   occ   [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        reg_slice_cfg #(.PLD_WIDTH(W), .MODE(g)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .s_vld (s_vld[g]),
            .s_rdy (s_rdy[g]),
            .s_pld (s_pld[g]),
            .m_vld (m_vld[g]),
            .m_rdy (m_rdy[g]),
            .m_pld (m_pld[g]),
            .occ   (occ[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit armed = 1'b0;

    // Model: payloads accepted but not yet delivered, oldest first.
    logic [W-1:0] fifo [4][4];
    int           cnt  [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic run_cycle(input logic r, input int pv, input int pr);
        logic         e_srdy, e_mvld, up, dn;
        logic [W-1:0] e_mpld;
        @(negedge clk);
        rst = r;
        for (int m = 0; m < 4; m++) begin
            s_vld[m] = ($urandom_range(99) < pv);
            m_rdy[m] = ($urandom_range(99) < pr);
            s_pld[m] = W'($urandom);
        end
        #1;
        for (int m = 0; m < 4; m++) begin
            case (m)
                0: begin
                    e_srdy = m_rdy[m];
                    e_mvld = s_vld[m];
                    e_mpld = s_pld[m];
                end
                1: begin
                    e_srdy = (cnt[m] == 0) || m_rdy[m];
                    e_mvld = (cnt[m] > 0);
                    e_mpld = fifo[m][0];
                end
                2: begin
                    e_srdy = (cnt[m] == 0);
                    e_mvld = (cnt[m] > 0) || s_vld[m];
                    e_mpld = (cnt[m] > 0) ? fifo[m][0] : s_pld[m];
                end
                default: begin
                    e_srdy = (cnt[m] < 2);
                    e_mvld = (cnt[m] > 0);
                    e_mpld = fifo[m][0];
                end
            endcase
            if (armed) begin
                check($sformatf("m%0d_occ", m),   32'(occ[m]),   32'(cnt[m]));
                check($sformatf("m%0d_s_rdy", m), 32'(s_rdy[m]), 32'(e_srdy));
                check($sformatf("m%0d_m_vld", m), 32'(m_vld[m]), 32'(e_mvld));
                if (e_mvld)
                    check($sformatf("m%0d_m_pld", m), 32'(m_pld[m]), 32'(e_mpld));
            end
            up = s_vld[m] & e_srdy;
            dn = e_mvld & m_rdy[m];
            if (m != 0) begin
                if (r) begin
                    cnt[m] = 0;
                end else begin
                    if (up) begin
                        fifo[m][cnt[m]] = s_pld[m];
                        cnt[m]++;
                    end
                    if (dn) begin
                        for (int k = 0; k < 3; k++) fifo[m][k] = fifo[m][k+1];
                        cnt[m]--;
                    end
                end
            end
        end
        if (r) armed = 1'b1;
    endtask

    initial begin
        int pv, pr;
        rst = 1'b1;
        for (int m = 0; m < 4; m++) begin
            s_vld[m] = 1'b0;
            m_rdy[m] = 1'b0;
            s_pld[m] = '0;
            cnt[m]   = 0;
        end
        repeat (2) run_cycle(1'b1, 0, 0);
        // Streaming at full rate.
        repeat (20) run_cycle(1'b0, 100, 100);
        // Fill while stalled, then drain.
        repeat (3) run_cycle(1'b0, 100, 0);
        repeat (4) run_cycle(1'b0, 0, 100);
        // Fill, then reset while full with upstream still offering data.
        repeat (4) run_cycle(1'b0, 100, 0);
        run_cycle(1'b1, 100, 0);
        repeat (3) run_cycle(1'b0, 50, 50);
        // Random traffic with varying pressure and occasional resets.
        pv = 50;
        pr = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                pv = 10 + 30 * int'($urandom_range(3));
                pr = 10 + 30 * int'($urandom_range(3));
            end
            run_cycle(($urandom_range(299) == 0), pv, pr);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
